fetch_unit: RTL and testbench

Parametrised instruction-fetch front end. It replaces the fixed PC register and F1/F2 pipeline registers with a single block. It issues pipelined reads to the instruction SRAM, absorbs a configurable SRAM read latency, and buffers fetched instructions in a DEPTH-entry queue. Decode consumes instructions through a valid/ready handshake and steers fetch with a one-cycle redirect from branch/jump resolution.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; clear wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  fetch_entry_t                entry_i,
  input  logic                        pop_i,
  output fetch_entry_t                head_o,
  output logic                        valid_o,
  output logic [credit_w(DEPTH)-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = credit_w(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full, empty, do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full & ~clear_i;
  assign do_pop  = pop_i & ~empty & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o = ~empty;
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited SRAM issue, latency shift
// register and a decode-facing instruction queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          MEM_LAT  = 1,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        isram_cs,
  output logic [ADDR_W-1:0]           isram_addr,
  input  logic [31:0]                 isram_dataout,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_pc,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [31:0]                 dec_inst,
  output logic [31:0]                 dec_pc,
  output logic [credit_w(DEPTH)-1:0]  occupancy
);

  localparam int CW = credit_w(DEPTH);
  typedef logic [CW:0] credit_t;

  logic [31:0]        pc_q, pc_d;
  logic [MEM_LAT-1:0] fl_vld_q, fl_vld_d;
  logic [31:0]        fl_pc_q [MEM_LAT];
  logic [CW-1:0]      inflight, q_count;
  logic               issue, credit_ok, ret_vld, pop, q_valid;
  fetch_entry_t       head, push_entry;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(fl_vld_q[i]);
  end

  // Queued plus outstanding requests never exceed DEPTH, so returns always fit.
  assign credit_ok  = (credit_t'(q_count) + credit_t'(inflight)) < credit_t'(DEPTH);
  assign issue      = ~rst & ~redirect & credit_ok;
  assign isram_cs   = issue;
  assign isram_addr = pc_q[ADDR_W-1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = redirect_pc & ~32'h3;
    else if (issue) pc_d = pc_q + 32'd4;
  end

  always_comb begin
    fl_vld_d    = '0;
    fl_vld_d[0] = issue;
    for (int i = 1; i < MEM_LAT; i++) fl_vld_d[i] = fl_vld_q[i-1];
    if (redirect) fl_vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fl_vld_q <= '0;
    end else begin
      pc_q     <= pc_d;
      fl_vld_q <= fl_vld_d;
    end
  end

  // Slot PCs shift unconditionally; the valid vector decides which slots count.
  always_ff @(posedge clk) begin
    fl_pc_q[0] <= pc_q;
    for (int i = 1; i < MEM_LAT; i++) fl_pc_q[i] <= fl_pc_q[i-1];
  end

  assign ret_vld         = fl_vld_q[MEM_LAT-1];
  assign push_entry.pc   = fl_pc_q[MEM_LAT-1];
  assign push_entry.inst = isram_dataout;
  assign pop             = q_valid & dec_ready & ~redirect;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (redirect),
    .push_i  (ret_vld),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (q_valid),
    .count_o (q_count)
  );

  assign dec_valid = q_valid & ~rst;
  assign dec_inst  = dec_valid ? head.inst : NOP_INST;
  assign dec_pc    = dec_valid ? head.pc : 32'h0;
  assign occupancy = rst ? '0 : q_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three configurations driven in lockstep, each checked
// every cycle against a queue-based model, plus hand-computed spot checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, dec_ready;
  logic [31:0] redirect_pc;

  logic        cs_w   [3];
  logic [15:0] addr_w [3];
  logic        dv_w   [3];
  logic [31:0] inst_w [3];
  logic [31:0] pc_w   [3];
  logic [3:0]  occ_w  [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // u0: MEM_LAT=1 DEPTH=4, u1: MEM_LAT=3 DEPTH=2, u2: MEM_LAT=3 DEPTH=8
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int DEP = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    localparam int CW  = $clog2(DEP) + 1;

    logic          cs, dv;
    logic [15:0]   addr;
    logic [31:0]   dout, inst, pcv;
    logic [CW-1:0] occ;
    logic [31:0]   mem_pipe [LAT+1];

    fetch_unit #(
      .ADDR_W   (16),
      .MEM_LAT  (LAT),
      .DEPTH    (DEP),
      .RESET_PC (32'h0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .isram_cs      (cs),
      .isram_addr    (addr),
      .isram_dataout (dout),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .dec_valid     (dv),
      .dec_ready     (dec_ready),
      .dec_inst      (inst),
      .dec_pc        (pcv),
      .occupancy     (occ)
    );

    assign cs_w[g]   = cs;
    assign addr_w[g] = addr;
    assign dv_w[g]   = dv;
    assign inst_w[g] = inst;
    assign pc_w[g]   = pcv;
    assign occ_w[g]  = 4'(occ);

    // SRAM: data for a request taken in cycle t is presented throughout cycle t+LAT.
    assign dout = mem_pipe[LAT];
    always @(negedge clk) begin
      for (int i = LAT; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
      mem_pipe[0] <= cs ? ({16'h0, addr} ^ KEY) : 32'hDEAD_BEEF;
    end

    // Model: PC, list of outstanding requests with their due cycle, decode queue.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    logic [31:0] m_fl_pc[$];
    int          m_fl_due[$];
    int          m_cyc = 0;

    always @(negedge clk) begin
      logic        exp_cs, exp_dv;
      logic [31:0] hpc;
      exp_cs = !rst && !redirect && ((m_q.size() + m_fl_pc.size()) < DEP);
      exp_dv = !rst && (m_q.size() > 0);
      hpc    = (m_q.size() > 0) ? m_q[0] : 32'h0;

      chk1($sformatf("u%0d isram_cs", g), cs, exp_cs);
      if (exp_cs) chk32($sformatf("u%0d isram_addr", g), {16'h0, addr}, {16'h0, m_pc[15:0]});
      chk1($sformatf("u%0d dec_valid", g), dv, exp_dv);
      chk32($sformatf("u%0d dec_pc", g), pcv, exp_dv ? hpc : 32'h0);
      chk32($sformatf("u%0d dec_inst", g), inst,
            exp_dv ? ({16'h0, hpc[15:0]} ^ KEY) : NOP_INST);
      chk32($sformatf("u%0d occupancy", g), 32'(occ), rst ? 32'h0 : 32'(m_q.size()));

      if (rst) begin
        m_pc = 32'h0;
        m_q.delete(); m_fl_pc.delete(); m_fl_due.delete();
      end else if (redirect) begin
        m_q.delete(); m_fl_pc.delete(); m_fl_due.delete();
        m_pc = redirect_pc & ~32'h3;
      end else begin
        if (dec_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (m_fl_due.size() > 0 && m_fl_due[0] == m_cyc) begin
          m_q.push_back(m_fl_pc.pop_front());
          void'(m_fl_due.pop_front());
        end
        if (exp_cs) begin
          m_fl_pc.push_back(m_pc);
          m_fl_due.push_back(m_cyc + LAT);
          m_pc = m_pc + 32'd4;
        end
      end
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;

    tick(); #2;
    chk1 ("rst u0 isram_cs",  cs_w[0], 1'b0);
    chk1 ("rst u0 dec_valid", dv_w[0], 1'b0);
    chk32("rst u0 dec_inst",  inst_w[0], NOP_INST);
    chk32("rst u0 dec_pc",    pc_w[0], 32'h0);
    chk32("rst u0 occupancy", {28'h0, occ_w[0]}, 32'h0);

    // Cycle R: first cycle out of reset
    tick(); rst = 1'b0; #2;
    chk1 ("R u0 isram_cs", cs_w[0], 1'b1);
    chk32("R u0 isram_addr", {16'h0, addr_w[0]}, 32'h0);
    chk1 ("R u1 isram_cs", cs_w[1], 1'b1);
    chk1 ("R u2 isram_cs", cs_w[2], 1'b1);
    tick(); #2;
    chk32("R+1 u0 isram_addr", {16'h0, addr_w[0]}, 32'h4);
    chk1 ("R+1 u0 dec_valid", dv_w[0], 1'b0);
    tick(); #2;
    chk1 ("R+2 u0 dec_valid", dv_w[0], 1'b1);
    chk32("R+2 u0 dec_pc", pc_w[0], 32'h0);
    chk32("R+2 u0 dec_inst", inst_w[0], 32'hA5A5_0000);
    chk1 ("R+2 u1 isram_cs", cs_w[1], 1'b0);
    tick(); #2;
    chk32("R+3 u0 dec_pc", pc_w[0], 32'h4);
    chk32("R+3 u0 dec_inst", inst_w[0], 32'hA5A5_0004);
    tick(); #2;
    chk1 ("R+4 u1 dec_valid", dv_w[1], 1'b1);
    chk32("R+4 u1 dec_pc", pc_w[1], 32'h0);
    chk32("R+4 u2 dec_pc", pc_w[2], 32'h0);
    // u1 regains a credit only the cycle after its head is popped.
    tick(); #2;
    chk32("R+5 u1 dec_pc", pc_w[1], 32'h4);
    chk1 ("R+5 u1 isram_cs", cs_w[1], 1'b1);
    chk32("R+5 u1 isram_addr", {16'h0, addr_w[1]}, 32'h8);
    chk32("R+5 u2 dec_pc", pc_w[2], 32'h4);
    tick(); #2;
    chk1 ("R+6 u1 dec_valid", dv_w[1], 1'b0);
    chk32("R+6 u2 dec_pc", pc_w[2], 32'h8);
    ticks(4); #2;
    chk32("R+10 u0 dec_pc", pc_w[0], 32'h20);
    chk32("R+10 u1 dec_pc", pc_w[1], 32'hC);
    chk32("R+10 u2 dec_pc", pc_w[2], 32'h18);

    // Cycle N: redirect while a return is arriving and decode is ready
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #2;
    chk1 ("N u0 isram_cs", cs_w[0], 1'b0);
    chk1 ("N u0 dec_valid", dv_w[0], 1'b1);
    chk32("N u0 dec_pc", pc_w[0], 32'h24);
    tick(); redirect = 1'b0; #2;
    chk1 ("N+1 u0 isram_cs", cs_w[0], 1'b1);
    chk32("N+1 u0 isram_addr", {16'h0, addr_w[0]}, 32'h0100);
    chk32("N+1 u0 occupancy", {28'h0, occ_w[0]}, 32'h0);
    chk1 ("N+1 u0 dec_valid", dv_w[0], 1'b0);
    tick(); #2;
    chk1 ("N+2 u0 dec_valid", dv_w[0], 1'b0);
    chk32("N+2 u0 isram_addr", {16'h0, addr_w[0]}, 32'h0104);
    tick(); #2;
    chk32("N+3 u0 dec_pc", pc_w[0], 32'h100);
    chk32("N+3 u0 dec_inst", inst_w[0], 32'hA5A5_0100);
    chk1 ("N+3 u2 dec_valid", dv_w[2], 1'b0);
    tick(); #2;
    chk32("N+4 u0 dec_pc", pc_w[0], 32'h104);
    tick(); #2;
    chk32("N+5 u2 dec_pc", pc_w[2], 32'h100);

    // Cycle M: redirect to the top of the address space so the PC wraps
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); redirect = 1'b0; #2;
    chk32("M+1 u0 isram_addr", {16'h0, addr_w[0]}, 32'hFFFC);
    tick(); #2;
    chk32("M+2 u0 isram_addr", {16'h0, addr_w[0]}, 32'h0000);
    tick(); #2;
    chk32("M+3 u0 dec_pc", pc_w[0], 32'hFFFF_FFFC);
    chk32("M+3 u0 dec_inst", inst_w[0], 32'hA5A5_FFFC);
    tick(); #2;
    chk32("M+4 u0 dec_pc", pc_w[0], 32'h0);
    chk32("M+4 u0 dec_inst", inst_w[0], 32'hA5A5_0000);
    tick(); redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect_pc = 32'h300;
    tick(); redirect = 1'b0; #2;
    chk1 ("M+7 u0 isram_cs", cs_w[0], 1'b1);
    chk32("M+7 u0 isram_addr", {16'h0, addr_w[0]}, 32'h0300);
    chk1 ("M+7 u0 dec_valid", dv_w[0], 1'b0);
    ticks(2); #2;
    chk32("M+9 u0 dec_pc", pc_w[0], 32'h300);

    // Cycle S: decode stalls until every configuration is full
    tick(); dec_ready = 1'b0;
    ticks(9); #2;
    chk32("S+9 u0 occupancy", {28'h0, occ_w[0]}, 32'h4);
    chk1 ("S+9 u0 isram_cs", cs_w[0], 1'b0);
    chk32("S+9 u1 occupancy", {28'h0, occ_w[1]}, 32'h2);
    chk1 ("S+9 u1 isram_cs", cs_w[1], 1'b0);
    chk32("S+9 u2 occupancy", {28'h0, occ_w[2]}, 32'h8);
    chk1 ("S+9 u2 isram_cs", cs_w[2], 1'b0);
    tick(); rst = 1'b1; #2;
    chk1 ("midrst u0 dec_valid", dv_w[0], 1'b0);
    chk32("midrst u0 occupancy", {28'h0, occ_w[0]}, 32'h0);
    chk32("midrst u0 dec_inst", inst_w[0], NOP_INST);
    chk1 ("midrst u0 isram_cs", cs_w[0], 1'b0);

    // Cycle R2: restart with decode still stalled
    tick(); rst = 1'b0; #2;
    chk1 ("R2 u0 dec_valid", dv_w[0], 1'b0);
    chk32("R2 u0 occupancy", {28'h0, occ_w[0]}, 32'h0);
    chk32("R2 u0 dec_inst", inst_w[0], NOP_INST);
    chk32("R2 u0 dec_pc", pc_w[0], 32'h0);
    chk1 ("R2 u0 isram_cs", cs_w[0], 1'b1);
    chk32("R2 u0 isram_addr", {16'h0, addr_w[0]}, 32'h0);
    ticks(3); #2;
    chk1 ("R2+3 u0 isram_cs", cs_w[0], 1'b1);
    chk32("R2+3 u0 isram_addr", {16'h0, addr_w[0]}, 32'hC);
    tick(); #2;
    chk1 ("R2+4 u0 isram_cs", cs_w[0], 1'b0);
    ticks(5); #2;
    chk1 ("R2+9 u0 isram_cs", cs_w[0], 1'b0);
    chk32("R2+9 u0 occupancy", {28'h0, occ_w[0]}, 32'h4);
    chk1 ("R2+9 u0 dec_valid", dv_w[0], 1'b1);
    chk32("R2+9 u0 dec_pc", pc_w[0], 32'h0);
    tick(); dec_ready = 1'b1;
    tick(); #2;
    chk32("R2+11 u0 dec_pc", pc_w[0], 32'h4);
    chk1 ("R2+11 u0 isram_cs", cs_w[0], 1'b1);
    chk32("R2+11 u0 isram_addr", {16'h0, addr_w[0]}, 32'h10);
    tick(); #2;
    chk32("R2+12 u0 dec_pc", pc_w[0], 32'h8);
    ticks(2); #2;
    chk32("R2+14 u0 dec_pc", pc_w[0], 32'h10);
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
